// File: rtl/change_dispenser.sv
// Change payout unit: pays a 10rs-unit amount greedily from 20rs/10rs hoppers
// over a four-phase eject handshake, tracking inventory and flagging faults.
module change_dispenser #(
    parameter int unsigned CNT_W       = 6,
    parameter int unsigned INIT_10     = 8,
    parameter int unsigned INIT_20     = 8,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       change,
    input  logic             change_vld,
    output logic             busy,
    output logic             eject_req,
    output logic             eject_sel,
    input  logic             eject_ack,
    input  logic             refill,
    input  logic             refill_sel,
    output logic [CNT_W-1:0] level10,
    output logic [CNT_W-1:0] level20,
    output logic             done,
    output logic             fault
);

    localparam int unsigned TO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LVL_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_REQ,
        S_RELEASE,
        S_DONE,
        S_FAULT
    } state_t;

    state_t          state, state_nxt;
    logic [2:0]      rem, rem_nxt;
    logic [TO_W-1:0] to_cnt, to_nxt;
    logic            sel_nxt;
    logic            dec10, dec20;
    logic [CNT_W-1:0] lvl10_nxt, lvl20_nxt;

    // Saturating refill combined with payout decrement; both together cancel.
    function automatic logic [CNT_W-1:0] lvl_upd(input logic [CNT_W-1:0] lvl,
                                                 input logic inc, input logic dec);
        logic [CNT_W-1:0] r;
        r = lvl;
        if (inc && !dec) begin
            r = (lvl == LVL_MAX) ? lvl : lvl + CNT_W'(1);
        end else if (dec && !inc) begin
            r = lvl - CNT_W'(1);
        end
        return r;
    endfunction

    // Next-state, remaining amount, hopper select and timeout counter.
    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        to_nxt    = to_cnt;
        sel_nxt   = eject_sel;
        dec10     = 1'b0;
        dec20     = 1'b0;
        case (state)
            S_IDLE: begin
                if (change_vld) begin
                    if (change == 3'd0) begin
                        state_nxt = S_DONE;
                    end else if (change <= 3'd5) begin
                        rem_nxt   = change;
                        state_nxt = S_SELECT;
                    end else begin
                        state_nxt = S_FAULT;
                    end
                end
            end
            S_SELECT: begin
                if (rem == 3'd0) begin
                    state_nxt = S_DONE;
                end else if (rem >= 3'd2 && level20 != '0) begin
                    sel_nxt   = 1'b1;
                    to_nxt    = '0;
                    state_nxt = S_REQ;
                end else if (level10 != '0) begin
                    sel_nxt   = 1'b0;
                    to_nxt    = '0;
                    state_nxt = S_REQ;
                end else begin
                    rem_nxt   = 3'd0;
                    state_nxt = S_FAULT;
                end
            end
            S_REQ: begin
                if (eject_ack) begin
                    dec20     = eject_sel;
                    dec10     = !eject_sel;
                    rem_nxt   = rem - (eject_sel ? 3'd2 : 3'd1);
                    state_nxt = S_RELEASE;
                end else if (to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
                    rem_nxt   = 3'd0;
                    state_nxt = S_FAULT;
                end else begin
                    to_nxt = to_cnt + TO_W'(1);
                end
            end
            S_RELEASE: begin
                if (!eject_ack) begin
                    state_nxt = S_SELECT;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            S_FAULT: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign lvl10_nxt = lvl_upd(level10, refill && !refill_sel, dec10);
    assign lvl20_nxt = lvl_upd(level20, refill && refill_sel, dec20);

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            rem       <= 3'd0;
            to_cnt    <= '0;
            busy      <= 1'b0;
            eject_req <= 1'b0;
            eject_sel <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
            level10   <= CNT_W'(INIT_10);
            level20   <= CNT_W'(INIT_20);
        end else begin
            state     <= state_nxt;
            rem       <= rem_nxt;
            to_cnt    <= to_nxt;
            busy      <= (state_nxt != S_IDLE);
            eject_req <= (state_nxt == S_REQ);
            eject_sel <= sel_nxt;
            done      <= (state_nxt == S_DONE);
            fault     <= (state_nxt == S_FAULT);
            level10   <= lvl10_nxt;
            level20   <= lvl20_nxt;
        end
    end

endmodule
